// File: rtl/ts_port_arbiter_if.sv
// Bundle of the event-write, scan-read and BRAM port signals around ts_port_arbiter.
// master = requesters + BRAM side, slave = the arbiter.
interface ts_port_arbiter_if #(
   parameter int ADDR_BITS  = 8,
   parameter int VALUE_BITS = 8
);
   logic                  ev_valid;
   logic [ADDR_BITS-1:0]  ev_addr;
   logic [VALUE_BITS-1:0] ev_value;
   logic                  ev_full;
   logic                  scan_re;
   logic [ADDR_BITS-1:0]  scan_addr;
   logic [VALUE_BITS-1:0] scan_rdata;
   logic                  mem_we;
   logic                  mem_re;
   logic [ADDR_BITS-1:0]  mem_addr;
   logic [VALUE_BITS-1:0] mem_wdata;
   logic [VALUE_BITS-1:0] mem_rdata;

   modport master (
      output ev_valid, ev_addr, ev_value, scan_re, scan_addr, mem_rdata,
      input  ev_full, scan_rdata, mem_we, mem_re, mem_addr, mem_wdata
   );

   modport slave (
      input  ev_valid, ev_addr, ev_value, scan_re, scan_addr, mem_rdata,
      output ev_full, scan_rdata, mem_we, mem_re, mem_addr, mem_wdata
   );
endinterface

// File: rtl/ts_port_arbiter.sv
// Single-port time-surface BRAM arbiter: scan reads always win, event writes queue and drain on idle cycles.
// Optional statistics (level_hwm, stats_clr) enabled by defining TS_ARB_STATS_EN.
module ts_port_arbiter #(
   parameter int ADDR_BITS     = 8,
   parameter int VALUE_BITS    = 8,
   parameter int FIFO_DEPTH    = 8,
   parameter int DROP_CNT_BITS = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   ts_port_arbiter_if.slave              bus,
   input  logic                          stats_clr,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [DROP_CNT_BITS-1:0]      drop_count,
   output logic [$clog2(FIFO_DEPTH):0]   level_hwm
);
   localparam int PTR_BITS = $clog2(FIFO_DEPTH);
   localparam int LVL_BITS = PTR_BITS + 1;
   localparam logic [LVL_BITS-1:0] FULL_LVL = LVL_BITS'(FIFO_DEPTH);

   logic [ADDR_BITS-1:0]  addr_q  [FIFO_DEPTH];
   logic [VALUE_BITS-1:0] value_q [FIFO_DEPTH];
   logic [PTR_BITS-1:0]   wr_ptr, rd_ptr;
   logic [LVL_BITS-1:0]   level, level_next;
   logic                  full, pop, push, drop, bypass;

   // An event arriving on an idle port with an empty queue goes straight to
   // the BRAM; ordering is preserved because nothing older is waiting.
   always_comb begin
      full          = (level == FULL_LVL);
      pop           = !bus.scan_re && (level != '0);
      bypass        = !bus.scan_re && (level == '0) && bus.ev_valid;
      bus.ev_full   = full && !pop;
      drop          = bus.ev_valid && full && !pop;
      push          = bus.ev_valid && !(full && !pop) && !bypass;
      bus.scan_rdata = bus.mem_rdata;
      bus.mem_we    = 1'b0;
      bus.mem_re    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (bus.scan_re) begin
         bus.mem_re   = 1'b1;
         bus.mem_addr = bus.scan_addr;
      end else if (pop) begin
         bus.mem_we    = 1'b1;
         bus.mem_addr  = addr_q[rd_ptr];
         bus.mem_wdata = value_q[rd_ptr];
      end else if (bypass) begin
         bus.mem_we    = 1'b1;
         bus.mem_addr  = bus.ev_addr;
         bus.mem_wdata = bus.ev_value;
      end
      level_next = level;
      if (push && !pop)      level_next = level + LVL_BITS'(1);
      else if (pop && !push) level_next = level - LVL_BITS'(1);
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr]  <= bus.ev_addr;
         value_q[wr_ptr] <= bus.ev_value;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_BITS'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
         level <= level_next;
      end
   end

   assign fifo_level = level;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_count <= '0;
`ifdef TS_ARB_STATS_EN
      end else if (stats_clr) begin
         drop_count <= '0;
`endif
      end else if (drop && (drop_count != '1)) begin
         drop_count <= drop_count + DROP_CNT_BITS'(1);
      end
   end

`ifdef TS_ARB_STATS_EN
   // Compared against level_next so the mark moves in step with fifo_level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                     level_hwm <= '0;
      else if (stats_clr)          level_hwm <= '0;
      else if (level_next > level_hwm) level_hwm <= level_next;
   end
`else
   assign level_hwm = '0;
   wire unused_stats_clr = stats_clr;
`endif
endmodule
